// File: rtl/fir_fold_pkg.sv
// Shared types and helpers for the folded FIR MAC scheduler.
// Define FIR_OUT_SAT_EN to make the output reduction saturate; otherwise it wraps.
package fir_fold_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} fir_fold_state_e;

    function automatic int acc_width(input int prod_w, input int ntaps);
        return prod_w + $clog2(ntaps);
    endfunction

    // Reduces a sign-extended sum to out_w bits; the caller keeps the low out_w bits.
    function automatic logic signed [63:0] reduce_out(input logic signed [63:0] v,
                                                      input int out_w);
`ifdef FIR_OUT_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/fir_fold_tap_bank.sv
// Partial-sum registers r[1..NTAPS-1] of the transposed FIR.
// One write port, one combinational read of r[ridx+1] that returns 0 past the last tap.
module fir_fold_tap_bank
    import fir_fold_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int ACC_W = 26,
    parameter int KW    = 2
)(
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    we,
    input  logic [KW-1:0]           widx,
    input  logic signed [ACC_W-1:0] wdata,
    input  logic [KW-1:0]           ridx,
    output logic signed [ACC_W-1:0] rdata
);

    logic signed [ACC_W-1:0] r [1:NTAPS-1];

    // NOTE: the bank is reset explicitly because an aborted sample must not leak into the next one.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 1; i < NTAPS; i++) r[i] <= '0;
        end else if (we) begin
            r[widx] <= wdata;
        end
    end

    // NOTE: default assignment first so the out-of-range read path cannot infer a latch.
    always_comb begin
        rdata = '0;
        if (int'(ridx) < NTAPS - 1) rdata = r[ridx + 1'b1];
    end

endmodule

// File: rtl/fir_fold_mac_scheduler.sv
// Folded transposed FIR: one sample in, NTAPS multiplies on an external shared multiplier, one sample out.
// Define FIR_OUT_SAT_EN for a saturating output; the default build wraps.
module fir_fold_mac_scheduler
    import fir_fold_pkg::*;
#(
    parameter int NTAPS  = 4,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int PROD_W = 24,
    parameter int ACC_W  = acc_width(PROD_W, NTAPS),
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0,
    localparam int KW    = $clog2(NTAPS)
)(
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [OUT_W-1:0]  m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     cfg_we,
    input  logic [KW-1:0]            cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    output logic                     cfg_err,
    output logic signed [DATA_W-1:0] mul_a,
    output logic [COEF_W-1:0]        mul_b,
    input  logic [PROD_W-1:0]        mul_p,
    output logic                     busy
);

    fir_fold_state_e         state;
    logic [KW-1:0]           k;
    logic [COEF_W-1:0]       coef [NTAPS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] tap_rd;
    logic                    cfg_ok;
    logic                    tap_we;
    logic [COEF_W-1:0]       coef0_next;

    assign p_ext  = ACC_W'($signed(mul_p));
    assign acc_sh = acc >>> SHIFT;
    assign cfg_ok = cfg_we && (state == IDLE) && (int'(cfg_addr) < NTAPS);
    assign tap_we = (state == MAC) && (k != '0);

    // A write to tap 0 in the accepting cycle must already feed the first multiply.
    assign coef0_next = (cfg_ok && cfg_addr == '0) ? cfg_data : coef[0];

    // Ascending k reads r[k+1] before r[k+1] itself is rewritten, so one bank suffices.
    fir_fold_tap_bank #(
        .NTAPS (NTAPS),
        .ACC_W (ACC_W),
        .KW    (KW)
    ) u_tap_bank (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .we     (tap_we),
        .widx   (k),
        .wdata  (p_ext + tap_rd),
        .ridx   (k),
        .rdata  (tap_rd)
    );

    // mul_a doubles as the latched sample x for the whole MAC phase.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            cfg_err <= 1'b0;
            busy    <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) coef[cfg_addr] <= cfg_data;

            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        state   <= MAC;
                        k       <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        mul_a   <= s_data;
                        mul_b   <= coef0_next;
                    end
                end
                MAC: begin
                    if (k == '0) acc <= p_ext + tap_rd;
                    if (k == KW'(NTAPS - 1)) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                        m_data  <= OUT_W'(reduce_out(64'(acc_sh), OUT_W));
                        mul_a   <= '0;
                        mul_b   <= '0;
                    end else begin
                        k     <= k + 1'b1;
                        mul_b <= coef[k + 1'b1];
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_fold_mac_scheduler.sv
// Scoreboard bench for fir_fold_mac_scheduler (NTAPS=4) plus a small NTAPS=3 instance for address range.
// Expected outputs depend on FIR_OUT_SAT_EN for the full-scale vector.
module tb_fir_fold_mac_scheduler;

    localparam int NTAPS = 4;

    typedef struct {
        logic signed [15:0] data;
        int                 acc_cyc;
    } exp_t;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_data;
    logic               cfg_err;
    logic signed [15:0] mul_a;
    logic [7:0]         mul_b;
    logic [23:0]        mul_p;
    logic               busy;
    logic signed [31:0] prod_full;

    logic               u3_s_ready;
    logic signed [15:0] u3_m_data;
    logic               u3_m_valid;
    logic               u3_cfg_we;
    logic [1:0]         u3_cfg_addr;
    logic [7:0]         u3_cfg_data;
    logic               u3_cfg_err;
    logic signed [15:0] u3_mul_a;
    logic [7:0]         u3_mul_b;
    logic [23:0]        u3_mul_p;
    logic signed [31:0] u3_prod_full;
    logic               u3_busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];
    logic mv_prev = 1'b0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    assign prod_full    = $signed({{16{mul_a[15]}}, mul_a}) * $signed({24'd0, mul_b});
    assign mul_p        = prod_full[23:0];
    assign u3_prod_full = $signed({{16{u3_mul_a[15]}}, u3_mul_a}) * $signed({24'd0, u3_mul_b});
    assign u3_mul_p     = u3_prod_full[23:0];

    fir_fold_mac_scheduler #(.NTAPS(NTAPS)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .busy     (busy)
    );

    fir_fold_mac_scheduler #(.NTAPS(3)) dut3 (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .s_data   (16'sd0),
        .s_valid  (1'b0),
        .s_ready  (u3_s_ready),
        .m_data   (u3_m_data),
        .m_valid  (u3_m_valid),
        .m_ready  (1'b1),
        .cfg_we   (u3_cfg_we),
        .cfg_addr (u3_cfg_addr),
        .cfg_data (u3_cfg_data),
        .cfg_err  (u3_cfg_err),
        .mul_a    (u3_mul_a),
        .mul_b    (u3_mul_b),
        .mul_p    (u3_mul_p),
        .busy     (u3_busy)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected the awaited event", name);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    // Monitor: latency on each m_valid rise, data on each output handshake.
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst) begin
            mv_prev = 1'b0;
        end else begin
            if (m_valid && !mv_prev && sb.size() != 0)
                check("latency", cyc - sb[0].acc_cyc, NTAPS);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got m_data=%0d, expected no output", m_data);
                end else begin
                    e = sb.pop_front();
                    check("m_data", m_data, e.data);
                end
            end
            mv_prev = m_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 100) begin
            step(1);
            n++;
        end
        if (!s_ready) fail_timeout("wait_s_ready");
    endtask

    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y);
        exp_t e;
        wait_ready();
        s_data  = x;
        s_valid = 1'b1;
        step(1);
        s_valid   = 1'b0;
        e.data    = y;
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        wait_ready();
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step(1);
        cfg_we = 1'b0;
        check("cfg_err_ok_write", cfg_err, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !s_ready) && n < 200) begin
            step(1);
            n++;
        end
        if (sb.size() != 0 || !s_ready) fail_timeout("drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"},  m_data,  0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_mul_a"},   mul_a,   0);
        check({tag, "_mul_b"},   mul_b,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        cfg_we  = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        u3_cfg_we   = 1'b0;
        u3_cfg_addr = '0;
        u3_cfg_data = '0;
        ap_rst = 1'b1;
        step(3);
        check_reset_outputs("reset");
        ap_rst = 1'b0;
        step(1);

        // Address range on the NTAPS=3 instance: index 2 is legal, index 3 is not.
        u3_cfg_we = 1'b1; u3_cfg_addr = 2'd2; u3_cfg_data = 8'd5;
        step(1);
        u3_cfg_we = 1'b0;
        check("u3_cfg_err_addr2", u3_cfg_err, 0);
        u3_cfg_we = 1'b1; u3_cfg_addr = 2'd3;
        step(1);
        u3_cfg_we = 1'b0;
        check("u3_cfg_err_addr3", u3_cfg_err, 1);
        step(1);
        check("u3_cfg_err_pulse_end", u3_cfg_err, 0);

        // Impulse response with coef {1,2,3,4}.
        cfg_write(2'd0, 8'd1);
        cfg_write(2'd1, 8'd2);
        cfg_write(2'd2, 8'd3);
        cfg_write(2'd3, 8'd4);
        send(16'sd100, 16'sd100);
        send(16'sd0, 16'sd200);
        send(16'sd0, 16'sd300);
        send(16'sd0, 16'sd400);
        send(16'sd0, 16'sd0);
        drain();

        // Negative sample: signed operand a against unsigned coefficient b.
        send(-16'sd5, -16'sd5);
        check("mul_a_signed", mul_a, -5);
        check("mul_b_k0", mul_b, 1);
        step(1);
        check("mul_b_k1", mul_b, 2);
        send(16'sd0, -16'sd10);
        send(16'sd0, -16'sd15);
        send(16'sd0, -16'sd20);
        drain();
        check("mul_a_idle", mul_a, 0);

        // Back-pressure: output held, no sample taken while in OUT.
        m_ready = 1'b0;
        send(16'sd7, 16'sd7);
        n = 0;
        while (!m_valid && n < 50) begin
            step(1);
            n++;
        end
        if (!m_valid) fail_timeout("m_valid_rise");
        s_data  = 16'sd1000;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_m_data", m_data, 7);
            check("hold_s_ready", s_ready, 0);
            step(1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        send(16'sd0, 16'sd14);
        send(16'sd0, 16'sd21);
        send(16'sd0, 16'sd28);
        send(16'sd0, 16'sd0);
        drain();

        // Write during MAC is dropped and flagged.
        send(16'sd10, 16'sd10);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd9;
        step(1);
        cfg_we = 1'b0;
        check("cfg_err_in_mac", cfg_err, 1);
        step(1);
        check("cfg_err_pulse_end", cfg_err, 0);
        send(16'sd0, 16'sd20);
        send(16'sd0, 16'sd30);
        send(16'sd0, 16'sd40);
        drain();

        // Write and handshake in the same IDLE cycle: the sample uses the new coef[0]=5.
        wait_ready();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd5;
        s_data = 16'sd3; s_valid = 1'b1;
        step(1);
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        e.data = 16'sd15;
        e.acc_cyc = cyc;
        sb.push_back(e);
        check("cfg_err_same_cycle", cfg_err, 0);
        drain();
        cfg_write(2'd0, 8'd1);
        send(16'sd0, 16'sd6);
        send(16'sd0, 16'sd9);
        send(16'sd0, 16'sd12);
        drain();

        // Full scale: exact sums 8355585 * {1,2,3,4}.
        cfg_write(2'd0, 8'd255);
        cfg_write(2'd1, 8'd255);
        cfg_write(2'd2, 8'd255);
        cfg_write(2'd3, 8'd255);
`ifdef FIR_OUT_SAT_EN
        send(16'sd32767, 16'sd32767);
        send(16'sd32767, 16'sd32767);
        send(16'sd32767, 16'sd32767);
        send(16'sd32767, 16'sd32767);
`else
        send(16'sd32767, 16'sd32513);
        send(16'sd32767, -16'sd510);
        send(16'sd32767, 16'sd32003);
        send(16'sd32767, -16'sd1020);
`endif
        drain();

        // Reset mid-MAC clears outputs at once, then coefficients read back as zero.
        send(16'sd100, 16'sd0);
        step(1);
        ap_rst = 1'b1;
        #1;
        sb.delete();
        check_reset_outputs("midreset");
        step(2);
        ap_rst = 1'b0;
        step(1);
        send(16'sd100, 16'sd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
